// File: rtl/seq_div_16_pkg.sv
// Shared constants and state type for the 16/8 sequential restoring divider.
package div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int ITER       = 16;
    localparam int CNT_W      = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div_16_if.sv
// Request/result bundle of the sequential divider.
// master drives operands and start; slave (the divider) returns the result.
interface seq_div_16_if;
    import div_pkg::*;

    logic                  start;
    logic [DIVIDEND_W-1:0] a;
    logic [DIVISOR_W-1:0]  b;
    logic [DIVIDEND_W-1:0] q;
    logic [DIVISOR_W-1:0]  r;
    logic                  busy;
    logic                  done;
    logic                  dz;

    modport master (output start, a, b, input  q, r, busy, done, dz);
    modport slave  (input  start, a, b, output q, r, busy, done, dz);

endinterface

// File: rtl/seq_div_16_step.sv
// One combinational restoring-division step.
// The remainder shifts left and takes in the dividend MSB, giving a 9-bit trial value.
// When the trial value is at least the divisor, the divisor is subtracted and the quotient bit is 1.
// The quotient bit enters the LSB of the shifted dividend, so after ITER steps that register holds the quotient.
// A restored remainder is always below the divisor, so 8 bits are enough to carry it between steps.
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W-1:0]  i_rem,
    input  logic [DIVIDEND_W-1:0] i_dvd,
    input  logic [DIVISOR_W-1:0]  i_dvs,
    output logic [DIVISOR_W-1:0]  o_rem,
    output logic [DIVIDEND_W-1:0] o_dvd
);
    logic [DIVISOR_W:0]   w_shift;
    logic [DIVISOR_W-1:0] w_diff;
    logic                 w_qbit;

    assign w_shift = {i_rem, i_dvd[DIVIDEND_W-1]};
    assign w_qbit  = (w_shift >= {1'b0, i_dvs});
    // Only used when w_qbit is set, where the true difference fits in 8 bits
    assign w_diff  = w_shift[DIVISOR_W-1:0] - i_dvs;
    assign o_rem   = w_qbit ? w_diff : w_shift[DIVISOR_W-1:0];
    assign o_dvd   = {i_dvd[DIVIDEND_W-2:0], w_qbit};

endmodule

// File: rtl/seq_div_16.sv
// seq_div_16: 16-bit / 8-bit unsigned sequential restoring divider.
// A rising edge on start in IDLE launches a division that takes 16 clocks.
// done pulses for one cycle when q/r first show the new result.
// Optional macro DIV_ZERO_CHECK_EN: a zero divisor bypasses the iterations.
// In that case the result (q = FFFF, r = a[7:0], dz = 1) is ready one clock after launch.
// Without the macro, dz is tied to 0 and a zero divisor runs the normal 16 steps.
module seq_div_16
    import div_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    seq_div_16_if.slave        bus
);
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_start_d;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_q;
    logic [DIVISOR_W-1:0]  r_r;

    logic                  w_launch;
    logic                  w_last;
    logic                  w_finish;
    logic                  w_busy;
    logic                  w_done;
    logic [DIVISOR_W-1:0]  w_rem_nxt;
    logic [DIVIDEND_W-1:0] w_dvd_nxt;

    assign w_launch = bus.start & ~r_start_d;
    assign w_last   = (r_cnt == CNT_W'(ITER - 1));

`ifdef DIV_ZERO_CHECK_EN
    logic r_zero;

    // Remember whether the launched divisor was zero, so RUN can finish after a single cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_zero <= 1'b0;
        end else if (r_state == IDLE && w_launch) begin
            r_zero <= (bus.b == '0);
        end
    end

    assign w_finish = w_last | r_zero;
    assign bus.dz   = w_done & r_zero;
`else
    assign w_finish = w_last;
    assign bus.dz   = 1'b0;
`endif

    div_step u_step (
        .i_rem (r_rem),
        .i_dvd (r_dvd),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_dvd (w_dvd_nxt)
    );

    // State register; reset wins over any start in the same cycle
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status decode
    always_comb begin
        // NOTE: every output gets a default first, so no path can leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_finish) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Start-edge history, operand latch and iteration datapath
    always_ff @(posedge clk) begin
        // NOTE: the datapath is a handful of flops rather than a memory array, so it is reset like the control.
        // This leaves no stale operands behind an aborted division.
        if (reset) begin
            r_start_d <= 1'b0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
        end else begin
            r_start_d <= bus.start;
            if (r_state == IDLE && w_launch) begin
                r_dvd <= bus.a;
                r_dvs <= bus.b;
                r_rem <= '0;
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_dvd <= w_dvd_nxt;
                r_rem <= w_rem_nxt;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Result registers; they change only on the edge that completes a division
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
            r_r <= '0;
        end else if (r_state == RUN && w_finish) begin
`ifdef DIV_ZERO_CHECK_EN
            if (r_zero) begin
                r_q <= '1;
                r_r <= r_dvd[DIVISOR_W-1:0];
            end else begin
                r_q <= w_dvd_nxt;
                r_r <= w_rem_nxt;
            end
`else
            r_q <= w_dvd_nxt;
            r_r <= w_rem_nxt;
`endif
        end
    end

    assign bus.q    = r_q;
    assign bus.r    = r_r;
    assign bus.busy = w_busy;
    assign bus.done = w_done;

endmodule

// File: doc/seq_div_16.md
SEQ_DIV_16 -- requirements
Module: seq_div_16

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports: clk  input  1  rising-edge clock.
REQ-002 The block SHALL have the port: reset  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have the port: start  input  1  request; only its rising edge (start high, previous-cycle start low) launches a division.
REQ-004 The block SHALL have the port: a  input  16  unsigned dividend, sampled on the launch edge.
REQ-005 The block SHALL have the port: b  input  8  unsigned divisor, sampled on the launch edge.
REQ-006 The block SHALL have the port: q  output  16  quotient, registered, held until the next completion.
REQ-007 The block SHALL have the port: r  output  8  remainder, registered, held until the next completion.
REQ-008 The block SHALL have the port: busy  output  1  high while an operation is in progress.
REQ-009 The block SHALL have the port: done  output  1  one-cycle pulse in the cycle q/r first show a new result.
REQ-010 The block SHALL have the port: dz  output  1  divide-by-zero flag, valid with done (see Configuration).

Function
REQ-011 The block SHALL have states IDLE, RUN and DONE: IDLE->RUN on a start rising edge; RUN->DONE after 16 iterations; DONE->IDLE unconditionally.
REQ-012 On the launch edge the block SHALL latch a and b, clear the 9-bit partial remainder and set the iteration count to 0.
REQ-013 Each RUN cycle SHALL perform one restoring step: rem = {rem[7:0], dividend MSB}; dividend shifts left; if rem >= {1'b0,b} then rem -= b and quotient bit = 1, else quotient bit = 0.
REQ-014 On the edge completing iteration 16, the block SHALL load q and r (r = rem[7:0]); done and dz SHALL then be high for exactly one cycle (DONE state).
REQ-015 Latency from launch edge to q/r valid SHALL be 16 clocks; busy SHALL be high for those 16 cycles and low in IDLE and DONE.
REQ-016 Start edges during RUN or DONE SHALL be ignored and never queued.
REQ-017 A start held high across completion SHALL NOT relaunch; a new low-to-high transition is required.
REQ-018 A launch edge in IDLE SHALL not alter q/r until the new completion.
REQ-019 The results SHALL satisfy a == q*b + r with r < b for every b != 0.

Reset
REQ-020 With reset high at a clock edge, the block SHALL enter IDLE and clear q, r, busy, done, dz, the internal registers and the start-edge history.
REQ-021 Reset mid-operation SHALL abort the division with no done pulse; reset SHALL take priority over start in the same cycle.

Configuration
REQ-022 With macro DIV_ZERO_CHECK_EN defined, a launch with b == 0 SHALL skip RUN, go to DONE on the next edge with q = 16'hFFFF, r = a[7:0] and dz = 1 during the done pulse, for a latency of 1 clock.
REQ-023 With DIV_ZERO_CHECK_EN undefined, dz SHALL be tied 0 and b == 0 SHALL run the normal 16 iterations, giving q = 16'hFFFF and r = a[7:0].

Structure
REQ-024 Shared package div_pkg SHALL hold the constants DIVIDEND_W = 16, DIVISOR_W = 8 and ITER = 16, plus the state enum type (IDLE, RUN, DONE).
REQ-025 The combinational restoring step (shift, compare, subtract, quotient bit) SHALL be a sub-module div_step, instantiated once.

Verification
REQ-026 Scenario: a = 117, b = 13 -> done 16 clocks after launch; q = 9, r = 0; dz = 0.
REQ-027 Scenario: a = 1000, b = 7 -> q = 142, r = 6; a = 16'h0005, b = 8'h0A -> q = 0, r = 5; a = 16'hFFFF, b = 1 -> q = 16'hFFFF, r = 0.
REQ-028 Scenario: b = 0, a = 16'h12AB -> q = 16'hFFFF, r = 8'hAB; with the macro, dz = 1 and latency 1; without it, dz = 0 and latency 16.
REQ-029 Scenario: start held high for 1.5 clocks, reset released mid-pulse -> no launch unless a low-to-high edge occurs after reset; exactly one done per edge.
REQ-030 Scenario: reset asserted at iteration 8 -> next cycle busy = 0, q = r = 0, no done pulse; a new launch then completes normally.
REQ-031 Scenario: start toggled during RUN with new a/b values -> ignored; the result matches the original operands.
